gray2bin_tracker: RTL and testbench

//  Receive end of a Gray-coded counter link. Synchronises a Gray count from another

---
 rtl/gray2bin_tracker.sv | 132 +++++++++++++
 tb/tb_gray2bin_tracker.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gray2bin_tracker.sv
// Receive side of a Gray-coded counter crossing: synchronise, decode to binary,
// and check that every change is a single +1/-1 step modulo 2^WIDTH.
module gray2bin_tracker #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             clr,
   output logic [WIDTH-1:0] bin_out,
   output logic             bin_valid,
   output logic             dir,
   output logic             step_err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] step_count
);

   typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

   localparam int FILL_W = $clog2(SYNC_STAGES + 2);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SYNC_STAGES + 1);

   state_t                             state_q, state_d;
   logic [FILL_W-1:0]                  fill_q, fill_d;
   logic [SYNC_STAGES-1:0][WIDTH-1:0]  sync_q;
   logic [WIDTH-1:0]                   dec_q;
   logic [WIDTH-1:0]                   bin_q, bin_d;
   logic                               valid_q, valid_d;
   logic                               dir_q, dir_d;
   logic                               err_q, err_d;
   logic                               sticky_q, sticky_d;
   logic [CNT_W-1:0]                   cnt_q, cnt_d;
   logic [WIDTH-1:0]                   diff;

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q   <= '0;
         dec_q    <= '0;
         state_q  <= IDLE;
         fill_q   <= '0;
         bin_q    <= '0;
         valid_q  <= 1'b0;
         dir_q    <= 1'b0;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], gray_in};
         dec_q    <= gray2bin(sync_q[SYNC_STAGES-1]);
         state_q  <= state_d;
         fill_q   <= fill_d;
         bin_q    <= bin_d;
         valid_q  <= valid_d;
         dir_q    <= dir_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   // bin_q doubles as the comparison baseline: it is always loaded together with it.
   assign diff = dec_q - bin_q;

   always_comb begin
      state_d  = state_q;
      fill_d   = fill_q;
      bin_d    = bin_q;
      valid_d  = 1'b0;
      dir_d    = dir_q;
      err_d    = 1'b0;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      if (clr) begin
         cnt_d    = '0;
         sticky_d = 1'b0;
         bin_d    = dec_q;
         state_d  = TRACK;
      end else begin
         case (state_q)
            IDLE: begin
               if (fill_q == FILL_LAST) begin
                  bin_d   = dec_q;
                  valid_d = 1'b1;
                  state_d = TRACK;
               end else begin
                  fill_d = fill_q + FILL_W'(1);
               end
            end
            TRACK: begin
               if (dec_q != bin_q) begin
                  bin_d   = dec_q;
                  valid_d = 1'b1;
                  if (diff == WIDTH'(1) || diff == {WIDTH{1'b1}}) begin
                     dir_d = (diff == WIDTH'(1));
                     if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                  end else begin
                     err_d    = 1'b1;
                     sticky_d = 1'b1;
                     state_d  = FAULT;
                  end
               end
            end
            FAULT: begin
               if (dec_q != bin_q) begin
                  bin_d   = dec_q;
                  valid_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bin_out    = bin_q;
   assign bin_valid  = valid_q;
   assign dir        = dir_q;
   assign step_err   = err_q;
   assign err_sticky = sticky_q;
   assign step_count = cnt_q;

endmodule

// File: tb/tb_gray2bin_tracker.sv
// Randomised bench for gray2bin_tracker: a step model predicts every bin_valid
// event into a queue and a negedge monitor pops and compares.
module tb_gray2bin_tracker;
   localparam int W     = 4;
   localparam int S     = 2;
   localparam int CW    = 16;
   localparam int CWS   = 4;
   localparam int MOD   = 1 << W;
   localparam int EXP_W = 3 + W + CW;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           clr = 1'b0;
   logic [W-1:0]   gray_in = '0;
   logic [W-1:0]   bin_out, bin_out_s;
   logic           bin_valid, dir, step_err, err_sticky;
   logic           bin_valid_s, dir_s, step_err_s, err_sticky_s;
   logic [CW-1:0]  step_count;
   logic [CWS-1:0] step_count_s;

   always #5 clk = ~clk;

   gray2bin_tracker #(.WIDTH(W), .SYNC_STAGES(S), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .gray_in(gray_in), .clr(clr),
      .bin_out(bin_out), .bin_valid(bin_valid), .dir(dir), .step_err(step_err),
      .err_sticky(err_sticky), .step_count(step_count)
   );

   gray2bin_tracker #(.WIDTH(W), .SYNC_STAGES(S), .CNT_W(CWS)) dut_sat (
      .clk(clk), .rst(rst), .gray_in(gray_in), .clr(clr),
      .bin_out(bin_out_s), .bin_valid(bin_valid_s), .dir(dir_s), .step_err(step_err_s),
      .err_sticky(err_sticky_s), .step_count(step_count_s)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [EXP_W-1:0] exp_q[$];

   int m_cur = 0;
   int m_prev = 0;
   int m_cnt = 0;
   bit m_dir = 0;
   bit m_sticky = 0;
   bit m_fault = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] to_gray(input int v);
      logic [W-1:0] b;
      b = W'(v);
      return b ^ (b >> 1);
   endfunction

   task automatic push_ev(input int b, input bit err);
      exp_q.push_back({m_sticky, m_dir, err, W'(b), CW'(m_cnt)});
   endtask

   task automatic model_reset();
      m_cnt = 0; m_dir = 0; m_sticky = 0; m_fault = 0; m_prev = m_cur;
   endtask

   // Apply a new value and predict what the tracker reports for it.
   task automatic set_value(input int v);
      int d;
      gray_in = to_gray(v);
      m_cur = v;
      if (v != m_prev) begin
         d = (v - m_prev + MOD) % MOD;
         if (m_fault) begin
            push_ev(v, 0);
         end else if (d == 1 || d == MOD - 1) begin
            m_dir = (d == 1);
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            push_ev(v, 0);
         end else begin
            m_sticky = 1; m_fault = 1;
            push_ev(v, 1);
         end
         m_prev = v;
      end
   endtask

   task automatic drive(input int v, input int hold);
      set_value(v);
      repeat (hold) @(negedge clk);
   endtask

   task automatic do_clr();
      repeat (2) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      m_cnt = 0; m_sticky = 0; m_fault = 0; m_prev = m_cur;
      repeat (2) @(negedge clk);
      check("clr_count", 32'(step_count), 0);
      check("clr_sticky", 32'(err_sticky), 0);
      check("clr_bin", 32'(bin_out), 32'(m_cur));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_bin"}, 32'(bin_out), 0);
      check({tag, "_valid"}, 32'(bin_valid), 0);
      check({tag, "_dir"}, 32'(dir), 0);
      check({tag, "_err"}, 32'(step_err), 0);
      check({tag, "_sticky"}, 32'(err_sticky), 0);
      check({tag, "_count"}, 32'(step_count), 0);
      check({tag, "_count_sat"}, 32'(step_count_s), 0);
   endtask

   // Returns negedges from now until bin_valid is seen (0 if never within the bound).
   task automatic wait_valid(output int lat);
      lat = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (bin_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (step_err && !bin_valid) check("err_without_valid", 32'(step_err), 0);
         if (bin_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 32'(bin_valid), 0);
            end else begin
               logic [EXP_W-1:0] e;
               int ecnt;
               e = exp_q.pop_front();
               ecnt = int'(e[CW-1:0]);
               check("bin_out", 32'(bin_out), 32'(e[CW+W-1:CW]));
               check("step_err", 32'(step_err), 32'(e[CW+W]));
               check("dir", 32'(dir), 32'(e[CW+W+1]));
               check("err_sticky", 32'(err_sticky), 32'(e[CW+W+2]));
               check("step_count", 32'(step_count), 32'(ecnt));
               check("step_count_sat", 32'(step_count_s), (ecnt > 15) ? 32'd15 : 32'(ecnt));
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int v;
      int r;

      // Reset with gray_in held at 0, then release and expect the baseline load.
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      model_reset();
      push_ev(m_cur, 0);
      wait_valid(lat);
      check("baseline_latency", 32'(lat), 32'(S + 2));
      repeat (6) @(negedge clk);

      // Full up-count 1..15 then wrap to 0, then four more ups past saturation of dut_sat.
      set_value(1);
      wait_valid(lat);
      check("step_latency", 32'(lat), 32'(S + 2));
      repeat (4) @(negedge clk);
      for (int k = 2; k <= 16; k++) drive(k % MOD, 8);
      check("count_after_wrap", 32'(step_count), 16);
      check("dir_after_wrap", 32'(dir), 1);
      for (int k = 1; k <= 4; k++) drive(k, 8);
      check("sat_hold", 32'(step_count_s), 15);

      // Walk down to 0, re-baseline, then 0 -> 15 is a legal down step.
      for (int k = 3; k >= 0; k--) drive(k, 8);
      do_clr();
      drive(15, 8);
      check("down_wrap_dir", 32'(dir), 0);
      check("down_wrap_count", 32'(step_count), 1);

      // Illegal jump 0 -> 2, frozen counting while faulted, then recovery via clr.
      drive(0, 8);
      do_clr();
      drive(2, 8);
      check("fault_sticky", 32'(err_sticky), 1);
      drive(3, 8);
      drive(9, 8);
      check("fault_frozen", 32'(step_count), 0);
      do_clr();
      drive(10, 8);
      check("recover_count", 32'(step_count), 1);

      // clr in the same cycle as an illegal step: no error is recorded.
      gray_in = to_gray(3);
      m_cur = 3;
      repeat (3) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      m_cnt = 0; m_sticky = 0; m_fault = 0; m_prev = m_cur;
      repeat (3) @(negedge clk);
      check("clr_wins_sticky", 32'(err_sticky), 0);
      check("clr_wins_bin", 32'(bin_out), 3);

      // Randomised walk: mostly legal single steps, some jumps and clears.
      for (int k = 0; k < 80; k++) begin
         r = $urandom_range(0, 99);
         if (r < 5) begin
            do_clr();
         end else begin
            if (r < 50) v = (m_cur + 1) % MOD;
            else if (r < 88) v = (m_cur + MOD - 1) % MOD;
            else v = $urandom_range(0, MOD - 1);
            drive(v, $urandom_range(S + 1, 8));
         end
      end

      // Asynchronous reset mid-operation at bin_out = 9, then re-baseline.
      drive(9, 8);
      check("pre_reset_queue_empty", 32'(exp_q.size()), 0);
      #2 rst = 1'b0;
      #1 check_all_zero("async_reset");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      model_reset();
      push_ev(m_cur, 0);
      wait_valid(lat);
      check("rebaseline_latency", 32'(lat), 32'(S + 2));
      repeat (6) @(negedge clk);
      check("rebaseline_no_err", 32'(err_sticky), 0);

      for (int k = 0; k < 20; k++) begin
         v = ($urandom_range(0, 1) == 1) ? (m_cur + 1) % MOD : (m_cur + MOD - 1) % MOD;
         drive(v, $urandom_range(S + 1, 8));
      end
      repeat (8) @(negedge clk);
      check("final_queue_empty", 32'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
